// File: rtl/dram_port_arbiter.sv
// -----------------------------------------------------------------------------
// dram_port_arbiter
//
// Shares one single-port synchronous DRAM macro (altsyncram style: address,
// data, rden, wren in; q out) among N_REQ core requesters. Requests are served
// round-robin, one memory access at a time. Each completed access returns a
// one-cycle acknowledge and, for reads, the read data.
//
// Access sequence per grant: IDLE -> ACCESS (enables high for one cycle) ->
// WAIT (READ_LAT cycles) -> DONE (o_ack pulse) -> IDLE.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       synchronous active-high reset
//   i_req       per-requester request level
//   i_we        per-requester write enable (1 = write, 0 = read)
//   i_addr      packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_wdata     packed write data, requester k at [k*DATA_W +: DATA_W]
//   o_ack       one-hot, one-cycle completion pulse
//   o_rdata     read data, valid in the o_ack cycle of a read
//   o_busy      high whenever the arbiter is not idle
//   o_mem_addr  DRAM address
//   o_mem_data  DRAM write data
//   o_mem_rden  DRAM read enable
//   o_mem_wren  DRAM write enable
//   i_mem_q     DRAM read data
// -----------------------------------------------------------------------------
module dram_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ-1:0]          i_we,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    input  logic [N_REQ*DATA_W-1:0]   i_wdata,
    output logic [N_REQ-1:0]          o_ack,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_busy,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_data,
    output logic                      o_mem_rden,
    output logic                      o_mem_wren,
    input  logic [DATA_W-1:0]         i_mem_q
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Counter holds READ_LAT-1 at most.
    localparam int CNT_W = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q,  state_d;
    logic [PTR_W-1:0]    ptr_q,    ptr_d;
    logic [N_REQ-1:0]    served_q, served_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [PTR_W-1:0]    sel_q,    sel_d;
    logic                we_q,     we_d;
    logic [N_REQ-1:0]    ack_q,    ack_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic [ADDR_W-1:0]   maddr_q,  maddr_d;
    logic [DATA_W-1:0]   mdata_q,  mdata_d;
    logic                rden_q,   rden_d;
    logic                wren_q,   wren_d;

    logic [N_REQ-1:0]    eligible;
    logic [PTR_W:0]      pick;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_found;

    // Returns {found, index} of the first set bit of elig, scanning
    // ptr, ptr+1, ... modulo N_REQ. The loop runs downward and overwrites,
    // so the lowest offset from ptr wins.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] elig,
                                               input logic [PTR_W-1:0] ptr);
        logic [PTR_W:0] res;
        int             idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (elig[idx[PTR_W-1:0]]) begin
                res = {1'b1, idx[PTR_W-1:0]};
            end
        end
        return res;
    endfunction

    // A requester already served stays masked until it drops i_req, so a
    // held-high request is never granted twice.
    assign eligible   = i_req & ~served_q;
    assign pick       = rr_pick(eligible, ptr_q);
    assign pick_found = pick[PTR_W];
    assign pick_idx   = pick[PTR_W-1:0];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        // Any requester sampled low loses its served mark on this edge.
        served_d = served_q & i_req;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        we_d     = we_q;
        ack_d    = '0;
        rdata_d  = rdata_q;
        maddr_d  = maddr_q;
        mdata_d  = mdata_q;
        rden_d   = 1'b0;
        wren_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    we_d    = i_we[pick_idx];
                    maddr_d = i_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    mdata_d = i_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    wren_d  = i_we[pick_idx];
                    rden_d  = ~i_we[pick_idx];
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // The DRAM samples on the edge closing this cycle.
                cnt_d   = CNT_W'(READ_LAT - 1);
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = i_mem_q;
                    end
                    ack_d[sel_q]    = 1'b1;
                    served_d[sel_q] = 1'b1;
                    ptr_d   = (sel_q == PTR_W'(N_REQ - 1)) ? '0 : sel_q + PTR_W'(1);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            served_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            served_q <= served_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            maddr_q  <= maddr_d;
            mdata_q  <= mdata_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_rdata    = rdata_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_mem_addr = maddr_q;
    assign o_mem_data = mdata_q;
    assign o_mem_rden = rden_q;
    assign o_mem_wren = wren_q;

endmodule
